// File: rtl/s2a_controller_if.sv
// s2a_controller_if: AXI write address/data/response handshake between the controller and memory
interface s2a_controller_if;
  logic [31:0] awaddr;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [1:0] bresp;
  modport master(output awaddr, awvalid, wvalid, wlast, bready, input awready, wready, bvalid, bresp);
  modport slave(input awaddr, awvalid, wvalid, wlast, bready, output awready, wready, bvalid, bresp);
endinterface

// File: rtl/s2a_controller.sv
// s2a_controller: stream samples into a ping-pong buffer, each finished half written as one 16-beat AXI burst
module s2a_controller (
  input  logic        rst,
  input  logic        Sclk,
  input  logic        sync,
  input  logic        Ien,
  output logic [4:0]  Iaddr,
  input  logic [31:0] ibase,
  input  logic [23:6] isize,
  output logic [23:6] iacnt,
  output logic [31:0] ibcnt,
  input  logic        AXI_clk,
  s2a_controller_if.master axi,
  output logic [4:0]  s2a_addr,
  output logic        s2a_en,
  output logic        s2a_err
);
  typedef enum logic [1:0] {IDLE, AW, W, B} state_t;
  logic [21:0] cnt;
  logic [31:0] bcnt, addr_reg, awaddr_n;
  logic half_reg, req_tgl, last_seg, req, unused;
  logic [2:0] tsync;
  state_t state, state_n;
  logic awvalid_n, wvalid_n, bready_n, err_n;
  logic [3:0] beat, beat_n;
  logic [4:0] sa_n;
  assign Iaddr = cnt[4:0];
  assign iacnt = cnt[21:4];
  assign ibcnt = bcnt;
  assign last_seg = cnt[21:4] == isize - 18'd1;
  assign unused = ^ibase[5:0];
  // addr_reg/half_reg are only sampled by the AXI side after the toggle crosses, and stay put for 16 samples
  always_ff @(posedge Sclk or posedge rst)
    if (rst) begin
      cnt <= '0;
      bcnt <= '0;
      addr_reg <= '0;
      half_reg <= 1'b0;
      req_tgl <= 1'b0;
    end else if (sync) begin
      cnt <= '0;
      bcnt <= '0;
    end else if (Ien && cnt[3:0] != 4'hf)
      cnt[3:0] <= cnt[3:0] + 4'd1;
    else if (Ien) begin
      cnt[3:0] <= 4'h0;
      addr_reg <= {ibase[31:6] + 26'(cnt[21:4]), 6'b0};
      half_reg <= cnt[4];
      req_tgl <= ~req_tgl;
      cnt[21:4] <= last_seg ? 18'd0 : cnt[21:4] + 18'd1;
      bcnt <= bcnt + {31'd0, last_seg};
    end
  assign req = tsync[2] ^ tsync[1];
  assign axi.wlast = axi.wvalid && beat == 4'hf;
  assign s2a_en = axi.wvalid && axi.wready;
  always_ff @(posedge AXI_clk or posedge rst)
    if (rst) begin
      tsync <= '0;
      state <= IDLE;
      axi.awaddr <= '0;
      axi.awvalid <= 1'b0;
      axi.wvalid <= 1'b0;
      axi.bready <= 1'b0;
      beat <= '0;
      s2a_addr <= '0;
      s2a_err <= 1'b0;
    end else begin
      tsync <= {tsync[1:0], req_tgl};
      state <= state_n;
      axi.awaddr <= awaddr_n;
      axi.awvalid <= awvalid_n;
      axi.wvalid <= wvalid_n;
      axi.bready <= bready_n;
      beat <= beat_n;
      s2a_addr <= sa_n;
      s2a_err <= err_n;
    end
  // a request arriving while a burst is still in flight is dropped and flagged
  always_comb begin
    state_n = state;
    awaddr_n = axi.awaddr;
    awvalid_n = axi.awvalid;
    wvalid_n = axi.wvalid;
    bready_n = axi.bready;
    beat_n = beat;
    sa_n = s2a_addr;
    err_n = s2a_err || (req && state != IDLE);
    case (state)
      IDLE: if (req) begin
        state_n = AW;
        awaddr_n = addr_reg;
        beat_n = 4'h0;
        sa_n = {half_reg, 4'h0};
        awvalid_n = 1'b1;
      end
      AW: if (axi.awready) begin
        state_n = W;
        awvalid_n = 1'b0;
        wvalid_n = 1'b1;
      end
      W: if (s2a_en) begin
        beat_n = beat + 4'd1;
        sa_n = {s2a_addr[4], s2a_addr[3:0] + 4'd1};
        if (axi.wlast) begin
          state_n = B;
          wvalid_n = 1'b0;
          bready_n = 1'b1;
        end
      end
      B: if (axi.bvalid) begin
        state_n = IDLE;
        bready_n = 1'b0;
        err_n = err_n || axi.bresp != 2'b00;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_s2a_controller.sv
// tb_s2a_controller: random stream stimulus against a sample-count model of bursts, addresses and counters
module tb_s2a_controller;
  logic rst = 0, Sclk = 0, AXI_clk = 0, sync = 0, Ien = 0;
  logic [4:0] Iaddr, s2a_addr;
  logic [31:0] ibase, ibcnt, din;
  logic [23:6] isize, iacnt;
  logic s2a_en, s2a_err;
  s2a_controller_if axi();
  s2a_controller dut(.rst(rst), .Sclk(Sclk), .sync(sync), .Ien(Ien), .Iaddr(Iaddr), .ibase(ibase),
    .isize(isize), .iacnt(iacnt), .ibcnt(ibcnt), .AXI_clk(AXI_clk), .axi(axi),
    .s2a_addr(s2a_addr), .s2a_en(s2a_en), .s2a_err(s2a_err));

  int n_chk = 0, n_fail = 0, b0 = 0, hb0 = 0;
  int unsigned k = 0;
  logic [31:0] mem [32];
  logic [31:0] pend[$], exp_d[$], exp_aw[$], aw_q[$], wd_q[$];
  int exp_sa[$], sa_q[$];
  logic wl_q[$];
  int bcount = 0, hold_bad = 0, wbeat = 0, aw_delay = 0, sh = 0;
  logic pav = 0, par = 0, pwv = 0, pwr = 0;
  logic [31:0] paw = 0;
  logic [4:0] psa = 0;
  bit aw_block = 0, stall_mode = 0;
  logic [1:0] bresp_next = 0;

  initial forever #20 Sclk = ~Sclk;
  initial begin #2; forever #5 AXI_clk = ~AXI_clk; end

  // external ping-pong buffer, written at the address the DUT supplies
  always @(posedge Sclk) if (Ien && !sync && !rst) mem[Iaddr] <= din;

  // observe the AXI side: accepted addresses, beats, responses, and hold violations
  always @(negedge AXI_clk) begin
    if (!rst) begin
      if (axi.awvalid && axi.awready) aw_q.push_back(axi.awaddr);
      if (s2a_en) begin
        wd_q.push_back(mem[s2a_addr]);
        sa_q.push_back(int'(s2a_addr));
        wl_q.push_back(axi.wlast);
      end
      bcount <= bcount + int'(axi.bvalid && axi.bready);
      hold_bad <= hold_bad + int'(pav && !par && (!axi.awvalid || axi.awaddr !== paw))
                           + int'(pwv && !pwr && (!axi.wvalid || s2a_addr !== psa));
    end
    wbeat <= rst ? 0 : s2a_en ? (axi.wlast ? 0 : wbeat + 1) : wbeat;
    pav <= axi.awvalid && !rst;
    par <= axi.awready;
    paw <= axi.awaddr;
    pwv <= axi.wvalid && !rst;
    pwr <= axi.wready;
    psa <= s2a_addr;
  end

  initial begin
    axi.awready = 0;
    forever begin
      @(posedge AXI_clk); #1;
      if (axi.awvalid && !aw_block) begin
        repeat (aw_delay) @(posedge AXI_clk);
        #1 axi.awready = 1;
        @(posedge AXI_clk); #1 axi.awready = 0;
      end
    end
  end

  initial begin
    axi.wready = 1;
    forever begin
      @(posedge AXI_clk); #1;
      if (stall_mode && (wbeat == 3 || wbeat == 9) && sh < 2) begin
        axi.wready = 0;
        sh++;
      end else begin
        axi.wready = 1;
        if (wbeat != 3 && wbeat != 9) sh = 0;
      end
    end
  end

  initial begin
    axi.bvalid = 0;
    axi.bresp = 0;
    forever begin
      @(posedge AXI_clk); #1;
      if (axi.bready && !axi.bvalid) begin
        axi.bvalid = 1;
        axi.bresp = bresp_next;
        bresp_next = 0;
        @(posedge AXI_clk); #1 axi.bvalid = 0;
        axi.bresp = 0;
      end
    end
  end

  task automatic feed(int n, bit gaps);
    int isz, seg;
    isz = int'(isize);
    for (int i = 0; i < n; ) begin
      @(negedge Sclk);
      seg = int'((k / 16) % isz);
      n_chk++;
      if ({Iaddr, iacnt, ibcnt} !== {5'((seg % 2) * 16 + k % 16), 18'(seg), 32'(k / (16 * isz))}) begin
        n_fail++;
        $display("FAIL counters k=%0d Iaddr/iacnt/ibcnt got %0d/%0d/%0d exp %0d/%0d/%0d", k, Iaddr, iacnt, ibcnt,
          (seg % 2) * 16 + k % 16, seg, k / (16 * isz));
      end
      if (gaps && $urandom_range(0, 3) == 0) Ien = 0;
      else begin
        Ien = 1;
        din = $urandom;
        pend.push_back(din);
        k++;
        i++;
        if (k % 16 == 0) begin
          seg = int'((k / 16 - 1) % isz);
          exp_aw.push_back((ibase & 32'hffff_ffc0) + 32'(seg * 64));
          exp_sa.push_back((seg % 2) * 16);
          foreach (pend[j]) exp_d.push_back(pend[j]);
          pend.delete();
        end
      end
    end
    @(negedge Sclk);
    Ien = 0;
  endtask

  task automatic test_reset(string tag);
    Ien = 0;
    sync = 0;
    rst = 1;
    #3;
    n_chk++;
    if ({Iaddr, iacnt, ibcnt} !== '0) begin n_fail++; $display("FAIL %s_counters got %h/%h/%h exp 0", tag, Iaddr, iacnt, ibcnt); end
    n_chk++;
    if ({axi.awaddr, axi.awvalid, axi.wvalid, axi.wlast, axi.bready} !== '0) begin
      n_fail++; $display("FAIL %s_axi awaddr/awv/wv/wl/br got %h/%b/%b/%b/%b exp 0", tag, axi.awaddr, axi.awvalid, axi.wvalid, axi.wlast, axi.bready);
    end
    n_chk++;
    if ({s2a_addr, s2a_en, s2a_err} !== '0) begin n_fail++; $display("FAIL %s_status addr/en/err got %0d/%b/%b exp 0", tag, s2a_addr, s2a_en, s2a_err); end
    repeat (4) @(posedge AXI_clk);
    k = 0;
    pend.delete(); exp_d.delete(); exp_aw.delete(); exp_sa.delete();
    aw_q.delete(); wd_q.delete(); sa_q.delete(); wl_q.delete();
    b0 = bcount;
    hb0 = hold_bad;
    @(negedge Sclk);
    rst = 0;
  endtask

  task automatic test_basic();
    ibase = 32'h1000_0000; isize = 4;
    test_reset("pre_basic");
    feed(32, 0);
    for (int i = 0; i < 4000 && bcount < b0 + exp_aw.size(); i++) @(posedge AXI_clk);
    n_chk++;
    if (aw_q.size() != exp_aw.size() || bcount != b0 + exp_aw.size()) begin n_fail++; $display("FAIL basic_count aw %0d b %0d exp %0d", aw_q.size(), bcount - b0, exp_aw.size()); end
    foreach (exp_aw[i]) begin n_chk++; if (aw_q[i] !== exp_aw[i]) begin n_fail++; $display("FAIL basic_awaddr[%0d] got %h exp %h", i, aw_q[i], exp_aw[i]); end end
    foreach (exp_d[i]) begin
      n_chk++;
      if ({wd_q[i], 5'(sa_q[i]), wl_q[i]} !== {exp_d[i], 5'(exp_sa[i / 16] + i % 16), i % 16 == 15}) begin
        n_fail++; $display("FAIL basic_beat[%0d] data/addr/last got %h/%0d/%b exp %h/%0d/%b", i, wd_q[i], sa_q[i], wl_q[i], exp_d[i], exp_sa[i / 16] + i % 16, i % 16 == 15);
      end
    end
    n_chk++;
    if (aw_q[1] !== 32'h1000_0040 || s2a_err !== 1'b0) begin n_fail++; $display("FAIL basic_second awaddr/err got %h/%b exp 10000040/0", aw_q[1], s2a_err); end
  endtask

  task automatic test_wrap();
    ibase = 32'h0; isize = 4;
    test_reset("pre_wrap");
    feed(64, 0);
    n_chk++;
    if (ibcnt !== 32'd1) begin n_fail++; $display("FAIL wrap_ibcnt64 got %0d exp 1", ibcnt); end
    feed(64, 0);
    n_chk++;
    if (ibcnt !== 32'd2 || iacnt !== 18'd0) begin n_fail++; $display("FAIL wrap_ibcnt128 got %0d/%0d exp 2/0", ibcnt, iacnt); end
    for (int i = 0; i < 4000 && bcount < b0 + exp_aw.size(); i++) @(posedge AXI_clk);
    n_chk++;
    if (aw_q.size() != exp_aw.size() || bcount != b0 + exp_aw.size()) begin n_fail++; $display("FAIL wrap_count aw %0d b %0d exp %0d", aw_q.size(), bcount - b0, exp_aw.size()); end
    foreach (exp_aw[i]) begin n_chk++; if (aw_q[i] !== exp_aw[i]) begin n_fail++; $display("FAIL wrap_awaddr[%0d] got %h exp %h", i, aw_q[i], exp_aw[i]); end end
    foreach (exp_d[i]) begin
      n_chk++;
      if ({wd_q[i], 5'(sa_q[i]), wl_q[i]} !== {exp_d[i], 5'(exp_sa[i / 16] + i % 16), i % 16 == 15}) begin
        n_fail++; $display("FAIL wrap_beat[%0d] data/addr/last got %h/%0d/%b exp %h/%0d/%b", i, wd_q[i], sa_q[i], wl_q[i], exp_d[i], exp_sa[i / 16] + i % 16, i % 16 == 15);
      end
    end
  endtask

  task automatic test_stall();
    ibase = $urandom; isize = 18'(2 * $urandom_range(1, 4));
    test_reset("pre_stall");
    aw_delay = 5;
    stall_mode = 1;
    feed(96, 1);
    for (int i = 0; i < 4000 && bcount < b0 + exp_aw.size(); i++) @(posedge AXI_clk);
    n_chk++;
    if (aw_q.size() != exp_aw.size() || bcount != b0 + exp_aw.size()) begin n_fail++; $display("FAIL stall_count aw %0d b %0d exp %0d", aw_q.size(), bcount - b0, exp_aw.size()); end
    foreach (exp_aw[i]) begin n_chk++; if (aw_q[i] !== exp_aw[i]) begin n_fail++; $display("FAIL stall_awaddr[%0d] got %h exp %h", i, aw_q[i], exp_aw[i]); end end
    foreach (exp_d[i]) begin
      n_chk++;
      if ({wd_q[i], 5'(sa_q[i]), wl_q[i]} !== {exp_d[i], 5'(exp_sa[i / 16] + i % 16), i % 16 == 15}) begin
        n_fail++; $display("FAIL stall_beat[%0d] data/addr/last got %h/%0d/%b exp %h/%0d/%b", i, wd_q[i], sa_q[i], wl_q[i], exp_d[i], exp_sa[i / 16] + i % 16, i % 16 == 15);
      end
    end
    n_chk++;
    if (hold_bad != hb0) begin n_fail++; $display("FAIL stall_hold violations got %0d exp 0", hold_bad - hb0); end
    aw_delay = 0;
    stall_mode = 0;
  endtask

  task automatic test_bresp();
    ibase = 32'h4000_0000; isize = 4;
    test_reset("pre_bresp");
    bresp_next = 2'b10;
    feed(16, 0);
    for (int i = 0; i < 4000 && bcount < b0 + 1; i++) @(posedge AXI_clk);
    repeat (2) @(posedge AXI_clk);
    n_chk++;
    if (s2a_err !== 1'b1) begin n_fail++; $display("FAIL bresp_err got %b exp 1", s2a_err); end
    feed(32, 0);
    for (int i = 0; i < 4000 && bcount < b0 + 3; i++) @(posedge AXI_clk);
    repeat (2) @(posedge AXI_clk);
    n_chk++;
    if (s2a_err !== 1'b1 || bcount != b0 + 3) begin n_fail++; $display("FAIL bresp_sticky err/bursts got %b/%0d exp 1/3", s2a_err, bcount - b0); end
  endtask

  task automatic test_overrun();
    ibase = 32'h3000_0000; isize = 8;
    test_reset("pre_overrun");
    aw_block = 1;
    feed(32, 0);
    repeat (10) @(posedge AXI_clk);
    n_chk++;
    if (s2a_err !== 1'b1) begin n_fail++; $display("FAIL overrun_err got %b exp 1", s2a_err); end
    n_chk++;
    if (axi.awvalid !== 1'b1 || aw_q.size() != 0) begin n_fail++; $display("FAIL overrun_held awvalid/aw got %b/%0d exp 1/0", axi.awvalid, aw_q.size()); end
    aw_block = 0;
    for (int i = 0; i < 4000 && bcount < b0 + 1; i++) @(posedge AXI_clk);
    repeat (200) @(posedge AXI_clk);
    n_chk++;
    if (aw_q.size() != 1 || bcount != b0 + 1) begin n_fail++; $display("FAIL overrun_single aw/b got %0d/%0d exp 1/1", aw_q.size(), bcount - b0); end
    n_chk++;
    if (aw_q[0] !== exp_aw[0] || s2a_err !== 1'b1) begin n_fail++; $display("FAIL overrun_addr addr/err got %h/%b exp %h/1", aw_q[0], s2a_err, exp_aw[0]); end
    aw_block = 1;
    feed(16, 0);
    repeat (10) @(posedge AXI_clk);
    n_chk++;
    if (axi.awvalid !== 1'b1) begin n_fail++; $display("FAIL midburst_awvalid got %b exp 1", axi.awvalid); end
    test_reset("mid_burst");
    aw_block = 0;
  endtask

  task automatic test_sync();
    ibase = 32'h2000_0000; isize = 4;
    test_reset("pre_sync");
    aw_delay = 5;
    feed(101, 0);
    n_chk++;
    if ({Iaddr, iacnt, ibcnt} !== {5'h05, 18'd2, 32'd1}) begin n_fail++; $display("FAIL sync_pre got %h/%0d/%0d exp 05/2/1", Iaddr, iacnt, ibcnt); end
    n_chk++;
    if ((axi.awvalid | axi.wvalid | axi.bready) !== 1'b1) begin n_fail++; $display("FAIL sync_inflight got 0 exp 1"); end
    sync = 1;
    Ien = 1;
    din = $urandom;
    k = 0;
    pend.delete();
    @(negedge Sclk);
    sync = 0;
    Ien = 0;
    n_chk++;
    if ({Iaddr, iacnt, ibcnt} !== '0) begin n_fail++; $display("FAIL sync_clear got %h/%0d/%0d exp 0/0/0", Iaddr, iacnt, ibcnt); end
    feed(16, 0);
    for (int i = 0; i < 4000 && bcount < b0 + exp_aw.size(); i++) @(posedge AXI_clk);
    n_chk++;
    if (aw_q.size() != exp_aw.size() || bcount != b0 + exp_aw.size()) begin n_fail++; $display("FAIL sync_count aw %0d b %0d exp %0d", aw_q.size(), bcount - b0, exp_aw.size()); end
    foreach (exp_aw[i]) begin n_chk++; if (aw_q[i] !== exp_aw[i]) begin n_fail++; $display("FAIL sync_awaddr[%0d] got %h exp %h", i, aw_q[i], exp_aw[i]); end end
    foreach (exp_d[i]) begin
      n_chk++;
      if ({wd_q[i], 5'(sa_q[i]), wl_q[i]} !== {exp_d[i], 5'(exp_sa[i / 16] + i % 16), i % 16 == 15}) begin
        n_fail++; $display("FAIL sync_beat[%0d] data/addr/last got %h/%0d/%b exp %h/%0d/%b", i, wd_q[i], sa_q[i], wl_q[i], exp_d[i], exp_sa[i / 16] + i % 16, i % 16 == 15);
      end
    end
    aw_delay = 0;
  endtask

  task automatic test_isize1();
    ibase = $urandom; isize = 1;
    test_reset("pre_isize1");
    for (int n = 1; n <= 4; n++) begin
      feed(16, 0);
      for (int i = 0; i < 4000 && bcount < b0 + n; i++) @(posedge AXI_clk);
    end
    n_chk++;
    if (ibcnt !== 32'd4 || iacnt !== 18'd0) begin n_fail++; $display("FAIL isize1_counts got %0d/%0d exp 4/0", ibcnt, iacnt); end
    n_chk++;
    if (aw_q.size() != exp_aw.size() || bcount != b0 + exp_aw.size()) begin n_fail++; $display("FAIL isize1_count aw %0d b %0d exp %0d", aw_q.size(), bcount - b0, exp_aw.size()); end
    foreach (exp_aw[i]) begin n_chk++; if (aw_q[i] !== exp_aw[i]) begin n_fail++; $display("FAIL isize1_awaddr[%0d] got %h exp %h", i, aw_q[i], exp_aw[i]); end end
    foreach (exp_d[i]) begin
      n_chk++;
      if ({wd_q[i], 5'(sa_q[i]), wl_q[i]} !== {exp_d[i], 5'(exp_sa[i / 16] + i % 16), i % 16 == 15}) begin
        n_fail++; $display("FAIL isize1_beat[%0d] data/addr/last got %h/%0d/%b exp %h/%0d/%b", i, wd_q[i], sa_q[i], wl_q[i], exp_d[i], exp_sa[i / 16] + i % 16, i % 16 == 15);
      end
    end
  endtask

  initial begin
    ibase = 0;
    isize = 4;
    #1;
    test_reset("init");
    test_basic();
    test_wrap();
    test_stall();
    test_bresp();
    test_overrun();
    test_sync();
    test_isize1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/s2a_controller.md
# s2a_controller

Stream-to-AXI write controller: the capture-side counterpart of the AXI-to-stream playback path. Stream samples enter a 32-word ping-pong buffer at Sclk, addressed by this block. Each completed 16-word half is written to memory as one 16-beat, 32-bit AXI INCR burst into a circular region of `isize` 64-byte segments at `ibase`. The block also provides segment and wrap counters for software.

## Interface
Parameters: none. Fixed AXI burst attributes are driven as constants outside this block: awlen=15, awsize=2, awburst=INCR, wstrb=4'hf.
- rst  in  1  system reset, asynchronous, active-high, applies to both clock domains
- Sclk  in  1  stream clock
- sync  in  1  Sclk-synchronous restart; clears stream counters
- Ien  in  1  stream sample valid; one buffer word written per Sclk cycle with Ien=1
- Iaddr  out  5  buffer write address (Sclk domain)
- ibase  in  32  region base address; bits [5:0] ignored
- isize  in  18 ([23:6])  region size in 64-byte segments, must be ≥1
- iacnt  out  18 ([23:6])  current segment index within region
- ibcnt  out  32  completed region wraps
- AXI_clk  in  1  AXI clock
- AXI_awaddr  out  32  burst address, 64-byte aligned
- AXI_awvalid  out  1
- AXI_awready  in  1
- AXI_wvalid  out  1
- AXI_wready  in  1
- AXI_wlast  out  1
- AXI_bvalid  in  1
- AXI_bresp  in  2
- AXI_bready  out  1
- s2a_addr  out  5  buffer read address; buffer read is combinational, so AXI_wdata = buf[s2a_addr]
- s2a_en  out  1  AXI_wvalid & AXI_wready (beat accepted)
- s2a_err  out  1  sticky error flag

## Operation
Sclk domain:
- 22-bit cnt; Iaddr=cnt[4:0], iacnt=cnt[21:4], ibcnt=bcnt.
- sync=1: cnt←0, bcnt←0. sync has priority over Ien in the same cycle, and the sample is dropped.
- Ien=1, cnt[3:0]≠f: cnt[3:0]+1.
- Ien=1, cnt[3:0]=f (half complete):
  - cnt[3:0]←0.
  - addr_reg←{ibase[31:6]+cnt[21:4], 6'b0}; the sum is truncated to 26 bits.
  - half_reg←cnt[4].
  - req_tgl toggles.
  - If cnt[21:4]=isize−1: cnt[21:4]←0 and bcnt+1 (bcnt wraps at 2^32). Otherwise cnt[21:4]+1.
- addr_reg and half_reg stay stable until the next half completes, which is at least 16 Sclk cycles later.

AXI_clk domain:
- req_tgl passes through a 2-FF synchronizer. An edge detected on the synchronized toggle gives a one-cycle req.
- FSM states: IDLE, AW, W, B.
  - IDLE, req: AXI_awaddr←addr_reg; beat←0; s2a_addr←{half_reg,4'h0}; go to AW with AXI_awvalid=1.
  - AW: hold awvalid. On awready&awvalid: awvalid←0, wvalid←1, go to W.
  - W: on s2a_en, beat+1 and s2a_addr[3:0]+1. AXI_wlast=1 while beat=15. On s2a_en with wlast: wvalid←0, bready←1, go to B.
  - B: on bvalid&bready: bready←0, go to IDLE. bresp≠2'b00 sets s2a_err.
- req outside IDLE is an overrun: s2a_err←1 and the request is dropped. The current burst continues unaffected.
- s2a_err is cleared only by rst.

## Timing
- Reset values: Iaddr=0, iacnt=0, ibcnt=0, AXI_awaddr=0, awvalid=0, wvalid=0, wlast=0, bready=0, s2a_addr=0, s2a_en=0, s2a_err=0, FSM=IDLE.
- Latency: AXI_awvalid rises 3–4 AXI_clk cycles after the Sclk edge that toggles req_tgl.
- awvalid and wvalid, once asserted, hold with stable address and data until accepted, per AXI.
- Minimum burst is AW (1) + W (16) + B (1) = 18 AXI_clk cycles. The system guarantees a burst completes within 16 Sclk periods; violation is reported as an overrun.
- sync mid-burst: the AXI burst in flight completes normally. The Sclk counters restart at 0.
- rst mid-burst: both domains return to reset values immediately.
- isize=1: every half completion wraps, so ibcnt increments every 16 samples and awaddr is always ibase.

## Test plan
- Reset, then 32 Ien cycles with ibase=0x1000_0000, isize=4: two bursts at 0x1000_0000 and 0x1000_0040. s2a_addr runs 0..15, then 16..31. wlast is set on beat 15 only; s2a_err=0.
- Continuous Ien for 128 samples, isize=4: awaddr sequence 0x00, 0x40, 0x80, 0xC0, 0x00, …; ibcnt=1 after sample 64 and 2 after 128; iacnt back to 0.
- awready delayed 5 cycles and wready deasserted on beats 3 and 9: addresses and data are held, 16 beats are delivered, and s2a_addr does not skip.
- bresp=2'b10 on one burst: s2a_err=1 and stays 1 through later good bursts until rst.
- Hold AXI_awready=0 for more than 16 Sclk periods with Ien continuous: overrun sets s2a_err=1, and the second request issues no extra AW.
- sync asserted at cnt=0x25: Iaddr=0, iacnt=0 and ibcnt=0 on the next Sclk cycle. The in-flight burst still ends with bready/bvalid.
